// File: rtl/easy6502_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : easy6502_pkg
//  Description : Shared types and constants for the RAM port arbiter slice:
//                arbiter state encoding, arbitration mode selectors and a
//                width helper for small counters/pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
package easy6502_pkg;

    // RUN: CPU owns the RAM port. GRANT: one secondary client owns it.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int MODE_FIXED = 0;  // lowest requesting index wins
    localparam int MODE_RR    = 1;  // first requester after the last winner

    // Bits needed to index n distinct values, never less than one.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational winner selection. Fixed mode returns the
//                lowest set request bit; round-robin mode returns the first
//                set bit strictly after i_ptr, wrapping to index 0.
//  Ports       : i_req    - request vector
//                i_ptr    - index of the previous winner (round-robin only)
//                i_mode   - 0 fixed priority, 1 round-robin
//                o_winner - one-hot winner, zero when no request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_CLIENTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [N_CLIENTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    input  logic                 i_mode,
    output logic [N_CLIENTS-1:0] o_winner
);

    logic w_found;

    // Two passes: the first looks only above the pointer (or everywhere in
    // fixed mode); the second is the wrap-around from index 0, which also
    // picks the previous winner again when it is the only requester.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int j = 0; j < N_CLIENTS; j++) begin
            if (!w_found && i_req[j] && (!i_mode || (j > int'(i_ptr)))) begin
                o_winner[j] = 1'b1;
                w_found     = 1'b1;
            end
        end
        for (int j = 0; j < N_CLIENTS; j++) begin
            if (!w_found && i_req[j]) begin
                o_winner[j] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares one synchronous RAM port between the 6502 CPU and up
//                to eight secondary clients. The CPU is only paused on an
//                instruction boundary (cpu_sync); a grant then lasts while
//                the winner keeps requesting, optionally capped at MAX_GRANT
//                cycles, and is followed by at least MIN_CPU_CYCLES of CPU
//                run time.
//  Ports       : clk, reset              - clock, sync active-high reset
//                cpu_addr/wdata/we/sync  - CPU bus and instruction strobe
//                cpu_rdy, cpu_rdata      - CPU ready and read data
//                req, gnt                - client request / one-hot grant
//                cli_addr/wdata/we       - packed client buses, slice i
//                cli_rdata, cli_rvalid   - shared read data, per-client valid
//                ram_addr/wdata/we/rdata - RAM port (1-cycle read latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import easy6502_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 8,
    parameter int N_CLIENTS      = 2,
    parameter int MODE           = 0,
    parameter int MIN_CPU_CYCLES = 0,
    parameter int MAX_GRANT      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    // CPU side
    input  logic [ADDR_WIDTH-1:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0]           cpu_wdata,
    input  logic                            cpu_we,
    input  logic                            cpu_sync,
    output logic                            cpu_rdy,
    output logic [DATA_WIDTH-1:0]           cpu_rdata,
    // Secondary clients
    input  logic [N_CLIENTS-1:0]            req,
    output logic [N_CLIENTS-1:0]            gnt,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cli_addr,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0] cli_wdata,
    input  logic [N_CLIENTS-1:0]            cli_we,
    output logic [DATA_WIDTH-1:0]           cli_rdata,
    output logic [N_CLIENTS-1:0]            cli_rvalid,
    // RAM port
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_wdata,
    output logic                            ram_we,
    input  logic [DATA_WIDTH-1:0]           ram_rdata
);

    localparam int PTR_W   = width_min1(N_CLIENTS);
    localparam int GUARD_W = width_min1(MIN_CPU_CYCLES + 1);
    localparam int GCNT_W  = width_min1(MAX_GRANT + 1);

    localparam logic [PTR_W-1:0]   c_PTR_RST    = PTR_W'(N_CLIENTS - 1);
    localparam logic [GUARD_W-1:0] c_GUARD_LOAD = GUARD_W'(MIN_CPU_CYCLES);
    localparam logic [GCNT_W-1:0]  c_GCNT_LAST  = GCNT_W'((MAX_GRANT > 0) ? MAX_GRANT - 1 : 0);
    localparam logic               c_LIMIT_EN   = (MAX_GRANT > 0);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [N_CLIENTS-1:0]   r_gnt;
    logic [N_CLIENTS-1:0]   w_gnt_nxt;
    logic                   r_cpu_rdy;
    logic [N_CLIENTS-1:0]   r_rvalid;
    logic [GUARD_W-1:0]     r_guard;
    logic [GCNT_W-1:0]      r_gcnt;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_boot;
    logic [N_CLIENTS-1:0]   w_winner;
    logic [PTR_W-1:0]       w_win_idx;
    logic                   w_grant_start;
    logic                   w_release;
    logic                   w_hold;
    logic                   w_limit;

    rr_pick #(
        .N_CLIENTS (N_CLIENTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .i_mode   (MODE == MODE_RR),
        .o_winner (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    assign w_hold  = |(req & r_gnt);
    assign w_limit = c_LIMIT_EN && (r_gcnt == c_GCNT_LAST);

    // Next-state and next-grant. r_boot marks the first cycle out of reset:
    // the CPU has not started an instruction yet, so a pending request may
    // be granted without waiting for cpu_sync. A release always goes back
    // through RUN so the CPU gets at least one instruction boundary.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = '0;
        w_grant_start = 1'b0;
        w_release     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if ((|req) && (r_guard == '0) && (cpu_sync || r_boot)) begin
                    w_state_nxt   = ST_GRANT;
                    w_gnt_nxt     = w_winner;
                    w_grant_start = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_hold || w_limit) begin
                    w_state_nxt = ST_RUN;
                    w_release   = 1'b1;
                end else begin
                    w_gnt_nxt = r_gnt;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_gnt     <= '0;
            r_cpu_rdy <= 1'b0;
            r_rvalid  <= '0;
            r_guard   <= '0;
            r_gcnt    <= '0;
            r_ptr     <= c_PTR_RST;
            r_boot    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cpu_rdy <= (w_state_nxt == ST_RUN);
            r_boot    <= 1'b0;

            // A granted read this cycle returns data from the RAM next cycle.
            if (r_state == ST_GRANT) begin
                r_rvalid <= r_gnt & ~cli_we;
            end else begin
                r_rvalid <= '0;
            end

            if (w_release) begin
                r_guard <= c_GUARD_LOAD;
            end else if ((r_state == ST_RUN) && (r_guard != '0)) begin
                r_guard <= r_guard - 1'b1;
            end

            // Counts completed grant cycles; only meaningful with a limit.
            if (c_LIMIT_EN && (r_state == ST_GRANT) && !w_release) begin
                r_gcnt <= r_gcnt + 1'b1;
            end else begin
                r_gcnt <= '0;
            end

            if (w_grant_start) begin
                r_ptr <= w_win_idx;
            end
        end
    end

    // RAM port mux. The CPU write enable is masked while the CPU is held
    // (reset and the cycle after it), so a write cannot leak out of reset
    // or out of an aborted grant.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we & r_cpu_rdy;
        if (r_state == ST_GRANT) begin
            ram_we = 1'b0;
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (r_gnt[i]) begin
                    ram_addr  = cli_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_wdata = cli_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    ram_we    = cli_we[i];
                end
            end
        end
    end

    assign cpu_rdy    = r_cpu_rdy;
    assign gnt        = r_gnt;
    assign cli_rvalid = r_rvalid;
    assign cpu_rdata  = ram_rdata;
    assign cli_rdata  = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Directed bench. Instance A (fixed priority, no guard, no
//                limit) is driven from a per-cycle vector table; instance B
//                (round-robin, MIN_CPU_CYCLES=3, MAX_GRANT=4) is driven by
//                hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Shared client buses: client0 at 0x100 / data 0x11, client1 at 0x010 / 0x22
    logic [21:0] cli_addr_c  = {11'h010, 11'h100};
    logic [15:0] cli_wdata_c = {8'h22, 8'h11};

    // ---------------- instance A ----------------
    logic        a_reset, a_cpu_we, a_cpu_sync;
    logic [10:0] a_cpu_addr;
    logic [7:0]  a_cpu_wdata = 8'h55;
    logic [1:0]  a_req, a_cli_we;
    logic [7:0]  a_ram_rdata;
    logic        a_cpu_rdy, a_ram_we;
    logic [7:0]  a_cpu_rdata, a_cli_rdata, a_ram_wdata;
    logic [1:0]  a_gnt, a_cli_rvalid;
    logic [10:0] a_ram_addr;

    ram_port_arbiter #(
        .ADDR_WIDTH(11), .DATA_WIDTH(8), .N_CLIENTS(2),
        .MODE(0), .MIN_CPU_CYCLES(0), .MAX_GRANT(0)
    ) dut_a (
        .clk(clk), .reset(a_reset),
        .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_we(a_cpu_we),
        .cpu_sync(a_cpu_sync), .cpu_rdy(a_cpu_rdy), .cpu_rdata(a_cpu_rdata),
        .req(a_req), .gnt(a_gnt),
        .cli_addr(cli_addr_c), .cli_wdata(cli_wdata_c), .cli_we(a_cli_we),
        .cli_rdata(a_cli_rdata), .cli_rvalid(a_cli_rvalid),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we),
        .ram_rdata(a_ram_rdata)
    );

    // ---------------- instance B ----------------
    logic        b_reset, b_cpu_we, b_cpu_sync;
    logic [10:0] b_cpu_addr  = 11'h300;
    logic [7:0]  b_cpu_wdata = 8'h66;
    logic [1:0]  b_req, b_cli_we;
    logic [7:0]  b_ram_rdata = 8'h00;
    logic        b_cpu_rdy, b_ram_we;
    logic [7:0]  b_cpu_rdata, b_cli_rdata, b_ram_wdata;
    logic [1:0]  b_gnt, b_cli_rvalid;
    logic [10:0] b_ram_addr;

    ram_port_arbiter #(
        .ADDR_WIDTH(11), .DATA_WIDTH(8), .N_CLIENTS(2),
        .MODE(1), .MIN_CPU_CYCLES(3), .MAX_GRANT(4)
    ) dut_b (
        .clk(clk), .reset(b_reset),
        .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_we(b_cpu_we),
        .cpu_sync(b_cpu_sync), .cpu_rdy(b_cpu_rdy), .cpu_rdata(b_cpu_rdata),
        .req(b_req), .gnt(b_gnt),
        .cli_addr(cli_addr_c), .cli_wdata(cli_wdata_c), .cli_we(b_cli_we),
        .cli_rdata(b_cli_rdata), .cli_rvalid(b_cli_rvalid),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
        .ram_rdata(b_ram_rdata)
    );

    typedef struct {
        logic        rst, sync, cwe;
        logic [10:0] caddr;
        logic [1:0]  req, clwe;
        logic        rdy;
        logic [1:0]  gnt;
        logic        rwe;
        logic [10:0] raddr;
        logic [7:0]  wdata;
        logic [1:0]  rv;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input int rst, input int sync, input int cwe,
                                input int caddr, input int req, input int clwe,
                                input int rdy, input int gnt, input int rwe,
                                input int raddr, input int wdata, input int rv);
        vec_t v;
        v.rst = 1'(rst);   v.sync = 1'(sync); v.cwe = 1'(cwe);
        v.caddr = 11'(caddr); v.req = 2'(req); v.clwe = 2'(clwe);
        v.rdy = 1'(rdy);   v.gnt = 2'(gnt);   v.rwe = 1'(rwe);
        v.raddr = 11'(raddr); v.wdata = 8'(wdata); v.rv = 2'(rv);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_gnt, prev_gnt;
        logic       exp_rdy;

        // Each row: inputs held for one cycle; expected outputs observed
        // just before the edge that ends that cycle.
        //             rst sync cwe caddr  req   clwe | rdy gnt   rwe raddr  wd    rv
        vecs[0]  = mk(1, 0, 1, 'h200, 'b00, 'b00, 0, 'b00, 0, 'h200, 'h55, 'b00);
        vecs[1]  = mk(0, 0, 0, 'h000, 'b00, 'b00, 0, 'b00, 0, 'h000, 'h55, 'b00);
        vecs[2]  = mk(0, 0, 1, 'h200, 'b00, 'b00, 1, 'b00, 1, 'h200, 'h55, 'b00);
        vecs[3]  = mk(0, 0, 0, 'h201, 'b10, 'b00, 1, 'b00, 0, 'h201, 'h55, 'b00);
        vecs[4]  = mk(0, 0, 0, 'h202, 'b10, 'b10, 1, 'b00, 0, 'h202, 'h55, 'b00);
        vecs[5]  = mk(0, 1, 0, 'h203, 'b10, 'b00, 1, 'b00, 0, 'h203, 'h55, 'b00);
        vecs[6]  = mk(0, 0, 1, 'h204, 'b10, 'b00, 0, 'b10, 0, 'h010, 'h22, 'b00);
        vecs[7]  = mk(0, 0, 0, 'h204, 'b10, 'b10, 0, 'b10, 1, 'h010, 'h22, 'b10);
        vecs[8]  = mk(0, 0, 0, 'h204, 'b01, 'b00, 0, 'b10, 0, 'h010, 'h22, 'b00);
        vecs[9]  = mk(0, 0, 0, 'h205, 'b01, 'b00, 1, 'b00, 0, 'h205, 'h55, 'b10);
        vecs[10] = mk(0, 1, 0, 'h206, 'b11, 'b00, 1, 'b00, 0, 'h206, 'h55, 'b00);
        vecs[11] = mk(0, 0, 0, 'h206, 'b11, 'b00, 0, 'b01, 0, 'h100, 'h11, 'b00);
        vecs[12] = mk(0, 0, 0, 'h206, 'b11, 'b01, 0, 'b01, 1, 'h100, 'h11, 'b01);
        vecs[13] = mk(0, 0, 0, 'h206, 'b10, 'b01, 0, 'b01, 1, 'h100, 'h11, 'b00);
        vecs[14] = mk(0, 1, 0, 'h207, 'b11, 'b00, 1, 'b00, 0, 'h207, 'h55, 'b00);
        vecs[15] = mk(1, 0, 0, 'h207, 'b11, 'b01, 0, 'b01, 1, 'h100, 'h11, 'b00);
        vecs[16] = mk(0, 0, 1, 'h208, 'b11, 'b01, 0, 'b00, 0, 'h208, 'h55, 'b00);
        vecs[17] = mk(0, 0, 0, 'h208, 'b01, 'b00, 0, 'b01, 0, 'h100, 'h11, 'b00);
        vecs[18] = mk(0, 0, 0, 'h208, 'b00, 'b00, 0, 'b01, 0, 'h100, 'h11, 'b01);
        vecs[19] = mk(0, 0, 1, 'h209, 'b00, 'b00, 1, 'b00, 1, 'h209, 'h55, 'b01);

        a_reset = 1'b1; a_cpu_we = 1'b0; a_cpu_sync = 1'b0; a_cpu_addr = '0;
        a_req = '0; a_cli_we = '0; a_ram_rdata = '0;
        b_reset = 1'b1; b_cpu_we = 1'b0; b_cpu_sync = 1'b0; b_req = '0; b_cli_we = '0;
        repeat (2) @(posedge clk);

        // ---------------- table-driven run on instance A ----------------
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_reset     = vecs[i].rst;
            a_cpu_sync  = vecs[i].sync;
            a_cpu_we    = vecs[i].cwe;
            a_cpu_addr  = vecs[i].caddr;
            a_req       = vecs[i].req;
            a_cli_we    = vecs[i].clwe;
            a_ram_rdata = 8'(8'h30 + i);
            #1;
            check($sformatf("a_vec%0d", i),
                  64'({a_cpu_rdy, a_gnt, a_ram_we, a_ram_addr, a_ram_wdata,
                       a_cli_rvalid, a_cpu_rdata, a_cli_rdata}),
                  64'({vecs[i].rdy, vecs[i].gnt, vecs[i].rwe, vecs[i].raddr,
                       vecs[i].wdata, vecs[i].rv, a_ram_rdata, a_ram_rdata}));
        end
        @(negedge clk);
        a_reset = 1'b1;

        // ---------------- instance B: reset release ----------------
        b_reset = 1'b0;
        #1;
        check("b_rst_hold", 64'({b_cpu_rdy, b_gnt, b_cli_rvalid}), 64'(5'b0_00_00));

        // Round-robin with both clients requesting and cpu_sync always high:
        // 4-cycle grants (limit), 4 RUN cycles (guard 3 counting down to 0),
        // winners alternating 0,1,0 starting after the reset pointer (1).
        @(negedge clk);
        b_req = 2'b11; b_cpu_sync = 1'b1;
        #1;
        check("b_rr_c0", 64'({b_cpu_rdy, b_gnt, b_cli_rvalid}), 64'(5'b1_00_00));
        prev_gnt = 2'b00;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (((c - 1) % 8) < 4) begin
                exp_rdy = 1'b0;
                exp_gnt = ((((c - 1) / 8) % 2) == 0) ? 2'b01 : 2'b10;
            end else begin
                exp_rdy = 1'b1;
                exp_gnt = 2'b00;
            end
            check($sformatf("b_rr_c%0d", c),
                  64'({b_cpu_rdy, b_gnt, b_cli_rvalid}),
                  64'({exp_rdy, exp_gnt, prev_gnt}));
            prev_gnt = exp_gnt;
        end

        // Guard expires but no grant until the next instruction boundary.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_cpu_sync = 1'b0;
            #1;
            check($sformatf("b_nosync%0d", k), 64'({b_cpu_rdy, b_gnt}), 64'(3'b1_00));
        end
        @(negedge clk);
        b_cpu_sync = 1'b1;
        #1;
        check("b_sync_cycle", 64'({b_cpu_rdy, b_gnt}), 64'(3'b1_00));

        // Previous winner was 0, so client 1 is next; its write reaches RAM.
        @(negedge clk);
        b_cpu_sync = 1'b0; b_cli_we = 2'b10;
        #1;
        check("b_grant1", 64'({b_cpu_rdy, b_gnt}), 64'(3'b0_10));
        check("b_cli_write", 64'({b_ram_we, b_ram_addr, b_ram_wdata}),
              64'({1'b1, 11'h010, 8'h22}));

        // Reset in the middle of the grant drops gnt and ram_we next edge.
        @(negedge clk);
        b_reset = 1'b1; b_cpu_we = 1'b1;
        #1;
        check("b_pre_reset", 64'({b_gnt, b_ram_we}), 64'(3'b10_1));
        @(negedge clk);
        #1;
        check("b_post_reset", 64'({b_cpu_rdy, b_gnt, b_ram_we, b_cli_rvalid}),
              64'(6'b0_00_0_00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
